// File: rtl/io_map_pkg.sv
// Register offsets and bit positions for the data-memory I/O window.
// Shared by the responder top and the testbench.
package io_map_pkg;

    localparam logic [31:0] OFF_CYCLE  = 32'h00;
    localparam logic [31:0] OFF_TCMP   = 32'h04;
    localparam logic [31:0] OFF_TCTRL  = 32'h08;
    localparam logic [31:0] OFF_TCNT   = 32'h0C;
    localparam logic [31:0] OFF_TSTAT  = 32'h10;
    localparam logic [31:0] OFF_TXDATA = 32'h14;
    localparam logic [31:0] OFF_TXSTAT = 32'h18;

    localparam int TCTRL_EN   = 0;
    localparam int TCTRL_AUTO = 1;
    localparam int TCTRL_IRQ  = 2;

    localparam int TSTAT_EXPIRED = 0;

    localparam int TXSTAT_FULL    = 0;
    localparam int TXSTAT_EMPTY   = 1;
    localparam int TXSTAT_OVF     = 2;
    localparam int TXSTAT_CNT_LSB = 8;

endpackage

// File: rtl/io_tx_fifo.sv
// Transmit FIFO with a push/full and pop/empty interface.
// A push while full is accepted only when a pop happens in the same cycle.
module io_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic                       full,
    output logic                       empty,
    output logic                       dropped,
    output logic [$clog2(DEPTH):0]     count,
    output logic [WIDTH-1:0]           head
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count_q;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign dropped = push && !push_ok;
    assign count   = count_q;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage is not reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/dmem_io_responder.sv
// I/O window responder on the CPU data-memory port: cycle counter,
// compare timer with interrupt, and a TX FIFO drained over valid/ready.
module dmem_io_responder
    import io_map_pkg::*;
#(
    parameter logic [31:0] IO_BASE    = 32'h0000_FF00,
    parameter int          WIN_BITS   = 8,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] MemAddr,
    input  logic [31:0] dataIn,
    input  logic        MemWrite,
    input  logic        MemRead,
    output logic        sel,
    output logic [31:0] dataOut,
    output logic        tx_valid,
    output logic [31:0] tx_data,
    input  logic        tx_ready,
    output logic        irq
);

    localparam logic [31:0] WIN_MASK = (32'h1 << WIN_BITS) - 32'h1;
    localparam int          CW       = $clog2(FIFO_DEPTH) + 1;

    logic [31:0]   off;
    logic          wr;
    logic          wr_tcmp, wr_tctrl, wr_tcnt, wr_tstat, wr_txdata, wr_txstat;
    logic [31:0]   cycle, tcmp, tcnt;
    logic [2:0]    tctrl;
    logic          expired, overflow;
    logic          hit, timer_step;
    logic          fifo_full, fifo_empty, fifo_drop;
    logic [CW-1:0] fifo_count;
    logic [31:0]   rdata;

    assign sel = ((MemAddr & ~WIN_MASK) == (IO_BASE & ~WIN_MASK));
    assign off = MemAddr & WIN_MASK & 32'hFFFF_FFFC;
    assign wr  = sel && MemWrite;

    assign wr_tcmp   = wr && (off == OFF_TCMP);
    assign wr_tctrl  = wr && (off == OFF_TCTRL);
    assign wr_tcnt   = wr && (off == OFF_TCNT);
    assign wr_tstat  = wr && (off == OFF_TSTAT);
    assign wr_txdata = wr && (off == OFF_TXDATA);
    assign wr_txstat = wr && (off == OFF_TXSTAT);

    // A CPU write to TCNT or TCTRL replaces this cycle's timer step entirely.
    assign hit        = (tcnt == tcmp);
    assign timer_step = tctrl[TCTRL_EN] && !wr_tctrl && !wr_tcnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cycle    <= '0;
            tcmp     <= 32'hFFFF_FFFF;
            tctrl    <= '0;
            tcnt     <= '0;
            expired  <= 1'b0;
            overflow <= 1'b0;
        end else begin
            cycle <= cycle + 32'd1;
            if (wr_tcmp) tcmp <= dataIn;

            if (wr_tctrl)
                tctrl <= dataIn[2:0];
            else if (timer_step && hit && !tctrl[TCTRL_AUTO])
                tctrl[TCTRL_EN] <= 1'b0;

            if (wr_tcnt)
                tcnt <= dataIn;
            else if (timer_step) begin
                if (!hit)                   tcnt <= tcnt + 32'd1;
                else if (tctrl[TCTRL_AUTO]) tcnt <= '0;
            end

            if (timer_step && hit)
                expired <= 1'b1;
            else if (wr_tstat && dataIn[TSTAT_EXPIRED])
                expired <= 1'b0;

            if (fifo_drop)
                overflow <= 1'b1;
            else if (wr_txstat && dataIn[TXSTAT_OVF])
                overflow <= 1'b0;
        end
    end

    io_tx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(32)) u_tx_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (wr_txdata),
        .push_data (dataIn),
        .pop       (tx_valid && tx_ready),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .dropped   (fifo_drop),
        .count     (fifo_count),
        .head      (tx_data)
    );

    assign tx_valid = !fifo_empty;
    assign irq      = expired && tctrl[TCTRL_IRQ];

    always_comb begin
        rdata = '0;
        case (off)
            OFF_CYCLE:  rdata = cycle;
            OFF_TCMP:   rdata = tcmp;
            OFF_TCTRL:  rdata = {29'd0, tctrl};
            OFF_TCNT:   rdata = tcnt;
            OFF_TSTAT:  rdata = {31'd0, expired};
            OFF_TXSTAT: begin
                rdata[TXSTAT_FULL]                      = fifo_full;
                rdata[TXSTAT_EMPTY]                     = fifo_empty;
                rdata[TXSTAT_OVF]                       = overflow;
                rdata[TXSTAT_CNT_LSB +: 8]              = 8'(fifo_count);
            end
            default:    rdata = '0;
        endcase
    end

    assign dataOut = (sel && MemRead) ? rdata : '0;

endmodule

// File: tb/tb_dmem_io_responder.sv
// Directed bench for dmem_io_responder: cycle counter, timer/irq, TX FIFO,
// address decode and reset, each scenario checked against hand-computed values.
module tb_dmem_io_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] MemAddr = '0;
    logic [31:0] dataIn = '0;
    logic        MemWrite = 1'b0;
    logic        MemRead = 1'b0;
    logic        sel;
    logic [31:0] dataOut;
    logic        tx_valid;
    logic [31:0] tx_data;
    logic        tx_ready = 1'b0;
    logic        irq;

    int pass_cnt = 0;
    int total_cnt = 0;

    dmem_io_responder dut (
        .clk      (clk),
        .rst      (rst),
        .MemAddr  (MemAddr),
        .dataIn   (dataIn),
        .MemWrite (MemWrite),
        .MemRead  (MemRead),
        .sel      (sel),
        .dataOut  (dataOut),
        .tx_valid (tx_valid),
        .tx_data  (tx_data),
        .tx_ready (tx_ready),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        MemAddr  = a;
        dataIn   = d;
        MemWrite = 1'b1;
        @(posedge clk);
        #1 MemWrite = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        MemAddr = a;
        MemRead = 1'b1;
        #1 d = dataOut;
        MemRead = 1'b0;
    endtask

    task automatic test_reset;
        logic [31:0] d, c0, c1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        rd(32'hFF00, c0);
        repeat (5) @(posedge clk);
        rd(32'hFF00, c1);
        total_cnt++;
        if (c1 - c0 !== 32'd5) $display("FAIL cycle_delta: got %0d want 5", c1 - c0); else pass_cnt++;
        rd(32'hFF04, d);
        total_cnt++;
        if (d !== 32'hFFFF_FFFF) $display("FAIL rst_tcmp: got %h want ffffffff", d); else pass_cnt++;
        rd(32'hFF08, d);
        total_cnt++;
        if (d !== 32'h0) $display("FAIL rst_tctrl: got %h want 0", d); else pass_cnt++;
        rd(32'hFF18, d);
        total_cnt++;
        if (d !== 32'h2) $display("FAIL rst_txstat: got %h want 2", d); else pass_cnt++;
        total_cnt++;
        if (irq !== 1'b0 || tx_valid !== 1'b0)
            $display("FAIL rst_outputs: got irq=%b tx_valid=%b want 0 0", irq, tx_valid);
        else pass_cnt++;
    endtask

    task automatic test_timer_oneshot;
        logic [31:0] d;
        wr(32'hFF04, 32'd3);
        wr(32'hFF0C, 32'd0);
        wr(32'hFF08, 32'b101);
        repeat (3) @(posedge clk);
        rd(32'hFF0C, d);
        total_cnt++;
        if (d !== 32'd3) $display("FAIL oneshot_tcnt3: got %0d want 3", d); else pass_cnt++;
        total_cnt++;
        if (irq !== 1'b0) $display("FAIL oneshot_irq_early: got %b want 0", irq); else pass_cnt++;
        @(posedge clk);
        rd(32'hFF10, d);
        total_cnt++;
        if (d !== 32'd1 || irq !== 1'b1)
            $display("FAIL oneshot_expired: got tstat=%h irq=%b want 1 1", d, irq);
        else pass_cnt++;
        rd(32'hFF08, d);
        total_cnt++;
        if (d !== 32'b100) $display("FAIL oneshot_en_clear: got %h want 4", d); else pass_cnt++;
        repeat (2) @(posedge clk);
        rd(32'hFF0C, d);
        total_cnt++;
        if (d !== 32'd3) $display("FAIL oneshot_tcnt_hold: got %0d want 3", d); else pass_cnt++;
        wr(32'hFF10, 32'd1);
        total_cnt++;
        if (irq !== 1'b0) $display("FAIL oneshot_w1c_irq: got %b want 0", irq); else pass_cnt++;
    endtask

    task automatic test_timer_reload;
        logic [31:0] d;
        logic [31:0] exp_seq [6];
        exp_seq = '{32'd0, 32'd1, 32'd2, 32'd0, 32'd1, 32'd2};
        wr(32'hFF0C, 32'd0);
        wr(32'hFF04, 32'd2);
        wr(32'hFF08, 32'b011);
        for (int i = 0; i < 6; i++) begin
            if (i != 0) @(posedge clk);
            rd(32'hFF0C, d);
            total_cnt++;
            if (d !== exp_seq[i])
                $display("FAIL reload_seq[%0d]: got %0d want %0d", i, d, exp_seq[i]);
            else pass_cnt++;
        end
        // This write commits on the same edge as the next expiry.
        wr(32'hFF10, 32'd1);
        rd(32'hFF10, d);
        total_cnt++;
        if (d !== 32'd1) $display("FAIL reload_set_wins: got %h want 1", d); else pass_cnt++;
        wr(32'hFF10, 32'd1);
        rd(32'hFF10, d);
        total_cnt++;
        if (d !== 32'd0) $display("FAIL reload_w1c: got %h want 0", d); else pass_cnt++;
        wr(32'hFF08, 32'd0);
    endtask

    task automatic test_fifo_overflow;
        logic [31:0] d;
        tx_ready = 1'b0;
        for (int i = 0; i < 5; i++) wr(32'hFF14, 32'hA + i);
        repeat (2) @(posedge clk);
        #1;
        total_cnt++;
        if (tx_valid !== 1'b1 || tx_data !== 32'hA)
            $display("FAIL ovf_head: got valid=%b data=%h want 1 0000000a", tx_valid, tx_data);
        else pass_cnt++;
        rd(32'hFF18, d);
        total_cnt++;
        if (d !== 32'h0405) $display("FAIL ovf_txstat: got %h want 00000405", d); else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total_cnt++;
            if (tx_valid !== 1'b1 || tx_data !== 32'hA + i)
                $display("FAIL ovf_pop[%0d]: got valid=%b data=%h want 1 %h", i, tx_valid, tx_data, 32'hA + i);
            else pass_cnt++;
            tx_ready = 1'b1;
        end
        @(negedge clk);
        tx_ready = 1'b0;
        total_cnt++;
        if (tx_valid !== 1'b0) $display("FAIL ovf_drained: got valid=%b want 0", tx_valid); else pass_cnt++;
        rd(32'hFF18, d);
        total_cnt++;
        if (d !== 32'h6) $display("FAIL ovf_empty_stat: got %h want 6", d); else pass_cnt++;
        wr(32'hFF18, 32'h4);
        rd(32'hFF18, d);
        total_cnt++;
        if (d !== 32'h2) $display("FAIL ovf_w1c: got %h want 2", d); else pass_cnt++;
    endtask

    task automatic test_back_to_back;
        logic [31:0] d;
        logic [31:0] exp_q [4];
        exp_q = '{32'h2, 32'h3, 32'h4, 32'h55};
        tx_ready = 1'b0;
        for (int i = 1; i <= 4; i++) wr(32'hFF14, i);
        @(negedge clk);
        MemAddr  = 32'hFF14;
        dataIn   = 32'h55;
        MemWrite = 1'b1;
        tx_ready = 1'b1;
        @(posedge clk);
        #1 MemWrite = 1'b0;
        tx_ready = 1'b0;
        rd(32'hFF18, d);
        total_cnt++;
        if (d !== 32'h0401) $display("FAIL b2b_txstat: got %h want 00000401", d); else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total_cnt++;
            if (tx_valid !== 1'b1 || tx_data !== exp_q[i])
                $display("FAIL b2b_pop[%0d]: got valid=%b data=%h want 1 %h", i, tx_valid, tx_data, exp_q[i]);
            else pass_cnt++;
            tx_ready = 1'b1;
        end
        @(negedge clk);
        tx_ready = 1'b0;
        total_cnt++;
        if (tx_valid !== 1'b0) $display("FAIL b2b_drained: got valid=%b want 0", tx_valid); else pass_cnt++;
    endtask

    task automatic test_decode_and_reset;
        logic [31:0] d;
        @(negedge clk);
        MemAddr  = 32'h0000_FE14;
        dataIn   = 32'h77;
        MemWrite = 1'b1;
        #1;
        total_cnt++;
        if (sel !== 1'b0) $display("FAIL dec_sel_out: got %b want 0", sel); else pass_cnt++;
        @(posedge clk);
        #1 MemWrite = 1'b0;
        total_cnt++;
        if (tx_valid !== 1'b0) $display("FAIL dec_no_push: got valid=%b want 0", tx_valid); else pass_cnt++;
        rd(32'hFF1C, d);
        total_cnt++;
        if (d !== 32'h0 || sel !== 1'b1)
            $display("FAIL dec_unmapped: got data=%h sel=%b want 0 1", d, sel);
        else pass_cnt++;
        rd(32'hFF14, d);
        total_cnt++;
        if (d !== 32'h0) $display("FAIL dec_txdata_rd: got %h want 0", d); else pass_cnt++;
        wr(32'hFF04, 32'h1234);
        wr(32'hFF14, 32'h11);
        wr(32'hFF14, 32'h22);
        @(negedge clk);
        rst      = 1'b1;
        MemAddr  = 32'hFF14;
        dataIn   = 32'h33;
        MemWrite = 1'b1;
        tx_ready = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        MemWrite = 1'b0;
        tx_ready = 1'b0;
        total_cnt++;
        if (tx_valid !== 1'b0) $display("FAIL rst_mid_valid: got %b want 0", tx_valid); else pass_cnt++;
        rd(32'hFF18, d);
        total_cnt++;
        if (d !== 32'h2) $display("FAIL rst_mid_txstat: got %h want 2", d); else pass_cnt++;
        rd(32'hFF00, d);
        total_cnt++;
        if (d !== 32'h0) $display("FAIL rst_mid_cycle: got %h want 0", d); else pass_cnt++;
        rd(32'hFF04, d);
        total_cnt++;
        if (d !== 32'hFFFF_FFFF) $display("FAIL rst_mid_tcmp: got %h want ffffffff", d); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_timer_oneshot();
        test_timer_reload();
        test_fifo_overflow();
        test_back_to_back();
        test_decode_and_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
